// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
// Optional build macro: MEM_ARB_RR_EN (round-robin conflict resolution).
package mem_arb_pkg;

    localparam int unsigned DATA_W = 32;

    // Which access, if any, was issued to the RAM in the previous cycle.
    typedef enum logic [1:0] {
        OUT_NONE = 2'd0,
        OUT_I    = 2'd1,
        OUT_D    = 2'd2,
        OUT_DW   = 2'd3
    } out_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker: at most one grant per cycle.
// On conflict D wins unless force_i is set.
module mem_arb_pick (
    input  logic i_req,
    input  logic d_req,
    input  logic force_i,
    output logic i_gnt,
    output logic d_gnt
);

    // One-hot grant from the two requests and the override.
    always_comb begin
        i_gnt = i_req && (!d_req || force_i);
        d_gnt = d_req && (!i_req || !force_i);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous-read RAM between the fetch (I) and data (D) ports.
// Default build: D priority with a starvation guard for fetch.
// Build macro MEM_ARB_RR_EN: round-robin on conflict instead.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    out_e              outstanding;
    logic [DATA_W-1:0] i_rdata_hold;
    logic [DATA_W-1:0] d_rdata_hold;
    logic              force_i;

    // Byte-lane bits and bits above the RAM range take no part in addressing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    // Requests are masked during reset so no access is issued in that cycle.
    mem_arb_pick u_pick (
        .i_req   (i_req && !rst),
        .d_req   (d_req && !rst),
        .force_i (force_i),
        .i_gnt   (i_gnt),
        .d_gnt   (d_gnt)
    );

`ifdef MEM_ARB_RR_EN
    logic last_winner_d; // 1: D won the most recent grant, 0: I did

    assign force_i = last_winner_d;

    // Remember the last winner so the other port takes the next conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner_d <= 1'b0;
        end else if (d_gnt) begin
            last_winner_d <= 1'b1;
        end else if (i_gnt) begin
            last_winner_d <= 1'b0;
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    assign force_i = (starve_cnt == STARVE_LIM);

    // Count fetch cycles lost to D; once at the limit, fetch wins the next conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (!i_req || i_gnt) begin
            starve_cnt <= 4'd0;
        end else if (d_gnt && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    // Drive the RAM from whichever port holds the grant.
    always_comb begin
        mem_en    = i_gnt || d_gnt;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_addr = d_addr[ADDR_W+1:2];
            if (d_we) begin
                mem_we    = d_be;
                mem_wdata = d_wdata;
            end
        end else if (i_gnt) begin
            mem_addr = i_addr[ADDR_W+1:2];
        end
    end

    // Track the issued access and keep the last read word of each port.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding  <= OUT_NONE;
            i_rdata_hold <= '0;
            d_rdata_hold <= '0;
        end else begin
            if (d_gnt) begin
                outstanding <= d_we ? OUT_DW : OUT_D;
            end else if (i_gnt) begin
                outstanding <= OUT_I;
            end else begin
                outstanding <= OUT_NONE;
            end
            if (outstanding == OUT_I) begin
                i_rdata_hold <= mem_rdata;
            end
            if (outstanding == OUT_D) begin
                d_rdata_hold <= mem_rdata;
            end
        end
    end

    // RAM data is presented in the response cycle and held afterwards;
    // a reset in the response cycle drops the response.
    always_comb begin
        i_rvalid = !rst && (outstanding == OUT_I);
        d_rvalid = !rst && ((outstanding == OUT_D) || (outstanding == OUT_DW));
        if (rst) begin
            i_rdata = '0;
            d_rdata = '0;
        end else begin
            i_rdata = (outstanding == OUT_I) ? mem_rdata : i_rdata_hold;
            d_rdata = (outstanding == OUT_D) ? mem_rdata : d_rdata_hold;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural byte-enabled sync RAM.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (10),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Behavioural RAM: word i holds 0x5A00_0000 + i, except word 16 holds 0x11223344.
    logic [31:0] ram [0:1023];
    logic        ram_init;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int w = 0; w < 1024; w++) begin
                ram[w] <= (w == 16) ? 32'h1122_3344 : 32'h5A00_0000 + 32'(w);
            end
        end else if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [3:0]  d_be;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_i_gnt;
        logic        e_d_gnt;
        logic        e_en;
        logic [3:0]  e_we;
        logic [9:0]  e_addr;
        logic [31:0] e_wdata;
        logic        e_i_rv;
        logic [31:0] e_i_rd;
        logic        e_d_rv;
        logic [31:0] e_d_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ram_init = 1'b1;
        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h8; d_wdata = 32'h0;

        // Fetch words 0..2, write/read word 16, wrapped read, idle.
        vecs[0] = '{1'b1, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b1, 4'h0, 10'h000, 32'h0,
                    1'b0, 32'h0, 1'b0, 32'h5A00_0002};
        vecs[1] = '{1'b1, 32'h4,  1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b1, 4'h0, 10'h001, 32'h0,
                    1'b1, 32'h5A00_0000, 1'b0, 32'h5A00_0002};
        vecs[2] = '{1'b1, 32'h8,  1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b1, 4'h0, 10'h002, 32'h0,
                    1'b1, 32'h5A00_0001, 1'b0, 32'h5A00_0002};
        vecs[3] = '{1'b0, 32'h0,  1'b1, 1'b1, 4'b0011, 32'h40, 32'hAABB_CCDD,
                    1'b0, 1'b1, 1'b1, 4'b0011, 10'h010, 32'hAABB_CCDD,
                    1'b1, 32'h5A00_0002, 1'b0, 32'h5A00_0002};
        vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 4'h0, 32'h40, 32'h0,
                    1'b0, 1'b1, 1'b1, 4'h0, 10'h010, 32'h0,
                    1'b0, 32'h5A00_0002, 1'b1, 32'h5A00_0002};
        vecs[5] = '{1'b0, 32'h0,  1'b1, 1'b0, 4'hF, 32'h0000_1004, 32'hFFFF_FFFF,
                    1'b0, 1'b1, 1'b1, 4'h0, 10'h001, 32'h0,
                    1'b0, 32'h5A00_0002, 1'b1, 32'h1122_CCDD};
        vecs[6] = '{1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0,
                    1'b0, 32'h5A00_0002, 1'b1, 32'h5A00_0001};
        vecs[7] = '{1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0,
                    1'b0, 32'h5A00_0002, 1'b0, 32'h5A00_0001};

        // Reset held three cycles with both ports requesting.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            ram_init = 1'b0;
            @(negedge clk);
            chk("rst_i_gnt", 32'(i_gnt), 32'h0);
            chk("rst_d_gnt", 32'(d_gnt), 32'h0);
            chk("rst_mem_en", 32'(mem_en), 32'h0);
            chk("rst_i_rvalid", 32'(i_rvalid), 32'h0);
            chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
            chk("rst_i_rdata", i_rdata, 32'h0);
            chk("rst_d_rdata", d_rdata, 32'h0);
        end

        // First cycle out of reset: D wins the conflict.
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_d_gnt", 32'(d_gnt), 32'h1);
        chk("post_rst_i_gnt", 32'(i_gnt), 32'h0);
        chk("post_rst_addr", 32'(mem_addr), 32'h2);

        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("post_rst_d_rvalid", 32'(d_rvalid), 32'h1);
        chk("post_rst_d_rdata", d_rdata, 32'h5A00_0002);
        chk("post_rst_i_rvalid", 32'(i_rvalid), 32'h0);

        // Table-driven single-port traffic.
        for (int v = 0; v < 8; v++) begin
            @(posedge clk); #1;
            i_req = vecs[v].i_req; i_addr = vecs[v].i_addr;
            d_req = vecs[v].d_req; d_we = vecs[v].d_we; d_be = vecs[v].d_be;
            d_addr = vecs[v].d_addr; d_wdata = vecs[v].d_wdata;
            @(negedge clk);
            chk($sformatf("v%0d_i_gnt", v), 32'(i_gnt), 32'(vecs[v].e_i_gnt));
            chk($sformatf("v%0d_d_gnt", v), 32'(d_gnt), 32'(vecs[v].e_d_gnt));
            chk($sformatf("v%0d_mem_en", v), 32'(mem_en), 32'(vecs[v].e_en));
            chk($sformatf("v%0d_mem_we", v), 32'(mem_we), 32'(vecs[v].e_we));
            chk($sformatf("v%0d_mem_addr", v), 32'(mem_addr), 32'(vecs[v].e_addr));
            chk($sformatf("v%0d_mem_wdata", v), mem_wdata, vecs[v].e_wdata);
            chk($sformatf("v%0d_i_rvalid", v), 32'(i_rvalid), 32'(vecs[v].e_i_rv));
            chk($sformatf("v%0d_i_rdata", v), i_rdata, vecs[v].e_i_rd);
            chk($sformatf("v%0d_d_rvalid", v), 32'(d_rvalid), 32'(vecs[v].e_d_rv));
            chk($sformatf("v%0d_d_rdata", v), d_rdata, vecs[v].e_d_rd);
        end

        // Sustained conflict after a fresh reset.
        @(posedge clk); #1;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h4;
        for (int k = 0; k < 10; k++) begin
            logic exp_i;
`ifdef MEM_ARB_RR_EN
            exp_i = (k % 2) == 1;
`else
            exp_i = (k % 5) == 4;
`endif
            @(negedge clk);
            chk($sformatf("starve%0d_i_gnt", k), 32'(i_gnt), 32'(exp_i));
            chk($sformatf("starve%0d_d_gnt", k), 32'(d_gnt), 32'(!exp_i));
            @(posedge clk); #1;
        end

        // Reset in the cycle after a fetch grant drops the response.
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'hC;
        @(negedge clk);
        chk("midrst_i_gnt", 32'(i_gnt), 32'h1);
        chk("midrst_addr", 32'(mem_addr), 32'h3);
        @(posedge clk); #1;
        rst = 1'b1; i_req = 1'b0;
        @(negedge clk);
        chk("midrst_i_rvalid", 32'(i_rvalid), 32'h0);
        chk("midrst_i_rdata", i_rdata, 32'h0);
        chk("midrst_d_rvalid", 32'(d_rvalid), 32'h0);
        chk("midrst_d_rdata", d_rdata, 32'h0);
        chk("midrst_i_gnt_low", 32'(i_gnt), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; i_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        chk("after_rst_i_rvalid", 32'(i_rvalid), 32'h0);
        chk("after_rst_i_rdata", i_rdata, 32'h0);
        chk("after_rst_d_first", 32'(d_gnt), 32'h1);
        chk("after_rst_i_lost", 32'(i_gnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
